// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO and its read-side streaming consumer.
//   DATA_WIDTH  : word width carried through the FIFO and onto the stream
//   BURST_W     : default width of burst length / transfer counters
//   rd_state_t  : state encoding of the read-side burst controller
//   burst_max   : largest burst length representable in a given counter width
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BURST_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    // Counters never wrap, so the longest legal burst is all-ones.
    function automatic int burst_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry in-order buffer that sits between the FIFO's registered read port
// and the downstream valid/ready stream. The head entry is always presented on
// 'head'; it only changes when it is popped, or when a word lands in an empty
// buffer, so the downstream word is stable while it is stalled.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (empties the buffer, head=0)
//   push       in   write push_data this cycle (caller guarantees occ<2 after pop)
//   push_data  in   word to write
//   pop        in   remove the head entry this cycle (ignored when empty)
//   occ        out  number of stored words, 0..2
//   head       out  oldest stored word
// -----------------------------------------------------------------------------
module fifo_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  do_pop;

    assign do_pop = pop && (occ_q != 2'd0);

    // Entries shift toward the head on a pop; a simultaneous push lands
    // behind whatever remains, which keeps word order strict.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push, do_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = push_data;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-domain consumer of the async FIFO. On 'start' it drains 'burst_len'
// words from the FIFO read port and presents them downstream as a valid/ready
// stream, using a 2-entry skid buffer to absorb the FIFO's one-cycle read
// latency so backpressure never drops or repeats a word.
// Ports:
//   clk_rd      in   read-domain clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a burst (accepted only when idle)
//   burst_len   in   words in the burst, sampled with start (0 = no reads)
//   abort       in   stop issuing reads, drain what is in flight, then finish
//   empty       in   FIFO empty flag
//   data_out    in   FIFO read data, valid the cycle after rd_en
//   rd_en       out  FIFO read strobe (combinational)
//   m_valid     out  downstream word valid
//   m_ready     in   downstream ready
//   m_data      out  downstream word
//   busy        out  burst in progress
//   done        out  one-cycle pulse at the end of a burst or abort
//   xfer_count  out  words handed downstream in the current/last burst
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BURST_W    = 8
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic                  abort,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done,
    output logic [BURST_W-1:0]    xfer_count
);

    import fifo_pkg::*;

    rd_state_t             state_q, state_d;
    logic [BURST_W-1:0]    len_q, len_d;
    logic [BURST_W-1:0]    issued_q, issued_d;
    logic [BURST_W-1:0]    xfer_q, xfer_d;
    logic                  inflight_q, inflight_d;

    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic [1:0]            occ_after_pop;
    logic                  room;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk_rd),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (data_out),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign pop = (occ != 2'd0) && m_ready;

    // Occupancy is credited with this cycle's pop: a word leaving downstream
    // frees its slot in time for the read issued now, which is what sustains
    // one word per cycle. A read issued here lands next cycle into at most
    // occ_after_pop + inflight_q <= 1 entries, so the buffer cannot overflow.
    assign occ_after_pop = occ - {1'b0, pop};
    assign room          = (occ_after_pop + {1'b0, inflight_q}) < 2'd2;

    assign rd_en = (state_q == READ) && !abort && !empty &&
                   (issued_q < len_q) && room;

    // Burst controller: next state plus the length/issue/transfer counters.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        xfer_d     = xfer_q;
        inflight_d = rd_en;

        if (rd_en) begin
            issued_d = issued_q + BURST_W'(1);
        end
        if (pop) begin
            xfer_d = xfer_q + BURST_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = burst_len;
                    issued_d = '0;
                    xfer_d   = '0;
                    state_d  = (burst_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if ((issued_q == len_q) || abort) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Finishing on the cycle the last word is accepted puts done
                // directly after the final handshake.
                if (!inflight_q && (occ_after_pop == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            xfer_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            xfer_q     <= xfer_d;
            inflight_q <= inflight_d;
        end
    end

    assign m_valid    = (occ != 2'd0);
    assign m_data     = head;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Bench for fifo_rd_stream. A simple array-backed FIFO feeds the DUT; a
// per-cycle checker holds a burst-level model (words must leave in the order
// they were read, one burst per start, one done per burst) and directed
// scenarios pin cycle timing with literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = fifo_pkg::DATA_WIDTH;
    localparam int BW = 8;

    logic          clk_rd;
    logic          rst_n;
    logic          start;
    logic [BW-1:0] burst_len;
    logic          abort;
    logic          empty;
    logic [DW-1:0] data_out;
    logic          rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
    logic [BW-1:0] xfer_count;

    int checks = 0;
    int errors = 0;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BURST_W    (BW)
    ) dut (
        .clk_rd     (clk_rd),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .empty      (empty),
        .data_out   (data_out),
        .rd_en      (rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done),
        .xfer_count (xfer_count)
    );

    initial clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    // Source FIFO: written by the stimulus, read at posedge when the checker
    // saw rd_en at the preceding negedge; data_out is registered.
    logic [DW-1:0] mem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          rd_fire = 1'b0;

    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk_rd) begin
        if (rd_fire) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model state, owned by the checker process.
    int            cyc = 0;
    logic          busy_m = 1'b0;
    int            len_m = 0;
    int            burst_rd = 0;
    int            burst_hs = 0;
    logic          aborted_m = 1'b0;
    int            hs_ptr = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_done = 1'b0;
    int            start_cyc = 0;
    int            first_valid_cyc = -1;
    int            first_hs_cyc = -1;
    int            last_hs_cyc = -1;
    int            done_cyc = -1;
    int            done_pulses = 0;
    logic [DW-1:0] first_word = '0;
    logic [DW-1:0] last_word = '0;

    // Per-cycle checker, sampling at negedge while inputs are stable.
    always @(negedge clk_rd) begin
        cyc++;
        rd_fire = rd_en && rst_n;
        if (!rst_n) begin
            busy_m     = 1'b0;
            burst_hs   = 0;
            hs_ptr     = rd_ptr;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            checkOutput("busy", 32'(busy), 32'(busy_m));
            checkOutput("xfer_count", 32'(xfer_count), 32'(burst_hs));
            if (!busy_m) checkOutput("idle_quiet", 32'({rd_en, m_valid, done}), 32'd0);
            if (rd_en) begin
                checkOutput("rd_en_while_empty", 32'(empty), 32'd0);
                checkOutput("rd_within_len", 32'(burst_rd < len_m), 32'd1);
                burst_rd++;
            end
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(m_valid), 32'd1);
                checkOutput("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                checkOutput("m_data_order", 32'(m_data), 32'(mem[hs_ptr]));
                if (burst_hs == 0) begin
                    first_word   = m_data;
                    first_hs_cyc = cyc;
                end
                last_word   = m_data;
                last_hs_cyc = cyc;
                hs_ptr++;
                burst_hs++;
            end
            if (abort && busy_m) aborted_m = 1'b1;
            if (done) begin
                checkOutput("done_in_burst", 32'(busy_m), 32'd1);
                checkOutput("done_single", 32'(prev_done), 32'd0);
                checkOutput("done_lossless", 32'(hs_ptr), 32'(rd_ptr));
                checkOutput("done_delivered", 32'(burst_hs),
                            aborted_m ? 32'(burst_rd) : 32'(len_m));
                done_cyc = cyc;
                done_pulses++;
                busy_m = 1'b0;
            end else if (start && !busy_m) begin
                busy_m          = 1'b1;
                len_m           = int'(burst_len);
                burst_rd        = 0;
                burst_hs        = 0;
                aborted_m       = 1'b0;
                start_cyc       = cyc;
                first_valid_cyc = -1;
                first_hs_cyc    = -1;
                last_hs_cyc     = -1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_done  = done;
        end
    end

    task automatic tick();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input int len, input logic ab,
                                 input logic rdy);
        start     = s;
        burst_len = BW'(len);
        abort     = ab;
        m_ready   = rdy;
    endtask

    task automatic writeWord(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic startBurst(input int len, input logic rdy);
        applyStimulus(1'b1, len, 1'b0, rdy);
        tick();
        applyStimulus(1'b0, len, 1'b0, rdy);
    endtask

    task automatic waitDone(input int budget);
        int p0 = done_pulses;
        int n = 0;
        while (done_pulses == p0 && n < budget) begin
            tick();
            n++;
        end
        if (done_pulses == p0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_xfer", 32'(xfer_count), 32'd0);
        checkOutput("reset_m_data", 32'(m_data), 32'd0);
    endtask

    initial begin
        int p0;
        int n;
        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        #1;
        checkResetOutputs();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Streaming 0x01..0x10 at full rate.
        for (int i = 1; i <= 16; i++) writeWord(DW'(i));
        startBurst(16, 1'b1);
        waitDone(100);
        tick();
        checkOutput("stream_first", 32'(first_word), 32'h01);
        checkOutput("stream_last", 32'(last_word), 32'h10);
        checkOutput("stream_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
        checkOutput("stream_back2back", 32'(last_hs_cyc - first_hs_cyc), 32'd15);
        checkOutput("stream_done_gap", 32'(done_cyc - last_hs_cyc), 32'd1);
        checkOutput("stream_xfer", 32'(xfer_count), 32'd16);

        // Empty stall: 3 words now, 2 more ten cycles later.
        p0 = done_pulses;
        for (int i = 0; i < 3; i++) writeWord(DW'(8'hA0 + i));
        startBurst(5, 1'b1);
        repeat (10) tick();
        checkOutput("stall_no_done_yet", 32'(done_pulses - p0), 32'd0);
        writeWord(8'hA3);
        writeWord(8'hA4);
        waitDone(100);
        repeat (4) tick();
        checkOutput("stall_one_done", 32'(done_pulses - p0), 32'd1);
        checkOutput("stall_xfer", 32'(xfer_count), 32'd5);
        checkOutput("stall_last", 32'(last_word), 32'hA4);

        // Backpressure: ready pattern 1,0,0 repeating.
        for (int i = 0; i < 6; i++) writeWord(DW'(8'hB0 + i));
        startBurst(6, 1'b1);
        p0 = done_pulses;
        n = 0;
        while (done_pulses == p0 && n < 200) begin
            applyStimulus(1'b0, 6, 1'b0, (n % 3) == 0);
            tick();
            n++;
        end
        if (done_pulses == p0) checkOutput("bp_timeout", 32'd0, 32'd1);
        checkOutput("bp_xfer", 32'(xfer_count), 32'd6);
        checkOutput("bp_last", 32'(last_word), 32'hB5);

        // Zero length, with a second start while still busy.
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        tick();
        p0 = done_pulses;
        applyStimulus(1'b1, 0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        repeat (5) tick();
        checkOutput("zero_one_done", 32'(done_pulses - p0), 32'd1);
        checkOutput("zero_done_timing", 32'(done_cyc - start_cyc), 32'd1);
        checkOutput("zero_no_reads", 32'(burst_rd), 32'd0);
        checkOutput("zero_xfer", 32'(xfer_count), 32'd0);

        // Abort after four reads, with downstream stalled for five cycles.
        for (int i = 0; i < 20; i++) writeWord(DW'(8'hC0 + i));
        startBurst(20, 1'b1);
        n = 0;
        while (burst_rd < 4 && n < 50) begin
            tick();
            n++;
        end
        applyStimulus(1'b0, 20, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 20, 1'b0, 1'b0);
        repeat (4) tick();
        applyStimulus(1'b0, 20, 1'b0, 1'b1);
        waitDone(100);
        tick();
        checkOutput("abort_xfer", 32'(xfer_count), 32'd4);
        checkOutput("abort_last", 32'(last_word), 32'hC3);

        // Reset mid-burst after three delivered words.
        for (int i = 0; i < 8; i++) writeWord(DW'(8'hD0 + i));
        startBurst(8, 1'b1);
        n = 0;
        while (burst_hs < 3 && n < 50) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        checkOutput("post_reset_valid", 32'(m_valid), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        // Randomized bursts with random backpressure and occasional abort.
        for (int b = 0; b < 12; b++) begin
            int len = int'($urandom_range(1, 12));
            int abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 10)) : -1;
            for (int i = 0; i < len; i++) writeWord(DW'($urandom));
            startBurst(len, 1'b1);
            p0 = done_pulses;
            n = 0;
            while (done_pulses == p0 && n < 300) begin
                applyStimulus(1'b0, len, n == abort_at, $urandom_range(0, 9) < 7);
                tick();
                n++;
            end
            if (done_pulses == p0) checkOutput("rand_timeout", 32'd0, 32'd1);
            applyStimulus(1'b0, 0, 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
